// File: rtl/bios_wdt_pkg.sv
// Shared definitions for the BIOS watchdog: FSM encoding, write-event bit
// positions, clock rate and counter widths.
package bios_wdt_pkg;

  localparam int CLK_HZ = 32768;
  localparam int PRE_W  = 15;
  localparam int SEC_W  = 8;
  localparam int WIN_W  = 8;
  localparam int CNT_W  = 4;
  localparam int EV_W   = 5;

  localparam int EV_55    = 0;
  localparam int EV_29    = 1;
  localparam int EV_FF    = 2;
  localparam int EV_AA    = 3;
  localparam int EV_OTHER = 4;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_UNLOCK   = 2'd2,
    ST_EXPIRED  = 2'd3
  } wdt_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bios_wdt_if.sv
// Bundle between the BIOS WDT register decode (master) and the watchdog
// controller (slave); dbg_state mirrors the controller FSM for observation.
interface bios_wdt_if;
  import bios_wdt_pkg::*;

  logic [EV_W-1:0]  bCPUWrWdtRegSig;
  logic             WdtDefaultEn;
  logic             BiosWdtActive;
  logic             BiosWdtTimeout;
  logic [CNT_W-1:0] BiosWdtExpCnt;
  logic [CNT_W-1:0] BiosWdtErrCnt;
  logic             BiosSelect;
  wdt_state_e       dbg_state;

  modport master (
    output bCPUWrWdtRegSig, WdtDefaultEn,
    input  BiosWdtActive, BiosWdtTimeout, BiosWdtExpCnt, BiosWdtErrCnt,
    input  BiosSelect, dbg_state
  );

  modport slave (
    input  bCPUWrWdtRegSig, WdtDefaultEn,
    output BiosWdtActive, BiosWdtTimeout, BiosWdtExpCnt, BiosWdtErrCnt,
    output BiosSelect, dbg_state
  );
endinterface

// File: rtl/bios_wdt_timer.sv
// Watchdog timebase: 15-bit prescaler producing a one-second tick and an
// 8-bit seconds down-counter. tc_o flags the edge on which seconds reach 0.
module bios_wdt_timer
  import bios_wdt_pkg::*;
#(
  parameter int unsigned TIMEOUT_SEC = 60
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic run_i,
  output logic tc_o
);

  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(CLK_HZ - 1);
  localparam logic [SEC_W-1:0] SEC_LOAD = SEC_W'(TIMEOUT_SEC);

  logic [PRE_W-1:0] pre_q;
  logic [SEC_W-1:0] sec_q;

  // Not gated by load_i: the controller resolves load-vs-expiry itself.
  assign tc_o = run_i && (pre_q == PRE_MAX) && (sec_q == SEC_W'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i || load_i) begin
      pre_q <= '0;
      sec_q <= SEC_LOAD;
    end else if (run_i) begin
      pre_q <= pre_q + 1'b1;
      if (pre_q == PRE_MAX && sec_q != '0) begin
        sec_q <= sec_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bios_wdt_ctrl.sv
// BIOS watchdog controller (CLK32768 domain): unlock/kick/disable protocol,
// timeout reporting and optional flash failover under BIOS_WDT_FAILOVER_EN.
module bios_wdt_ctrl
  import bios_wdt_pkg::*;
#(
  parameter int unsigned TIMEOUT_SEC = 60,
  parameter int unsigned UNLOCK_WIN  = 64
) (
  input  logic      CLK32768,
  input  logic      MainReset,
  bios_wdt_if.slave bus
);

  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(UNLOCK_WIN);
  localparam logic [EV_W-1:0]  EV_KICK  = EV_W'((1 << EV_55) | (1 << EV_AA));
  localparam logic [EV_W-1:0]  EV_DIS   = EV_W'((1 << EV_55) | (1 << EV_29));
  localparam logic [EV_W-1:0]  EV_AAONLY = EV_W'(1 << EV_AA);
  localparam logic [EV_W-1:0]  EV_29ONLY = EV_W'(1 << EV_29);

  wdt_state_e       state_q, state_d;
  logic [EV_W-1:0]  prev_q;
  logic [EV_W-1:0]  ev;
  logic             multi_ev;
  logic [WIN_W-1:0] win_q, win_d;
  logic             active_q, timeout_q;
  logic [CNT_W-1:0] exp_cnt_q, err_cnt_q;
  logic             err_inc, timer_load, timer_run, tc;

  assign ev       = bus.bCPUWrWdtRegSig ^ prev_q;
  assign multi_ev = |(ev & (ev - 1'b1));
  assign timer_run = (state_q == ST_ARMED) || (state_q == ST_UNLOCK);

  bios_wdt_timer #(.TIMEOUT_SEC(TIMEOUT_SEC)) u_timer (
    .clk_i  (CLK32768),
    .rst_i  (MainReset),
    .load_i (timer_load),
    .run_i  (timer_run),
    .tc_o   (tc)
  );

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    err_inc    = 1'b0;
    timer_load = 1'b0;
    case (state_q)
      ST_DISABLED: begin
        if (ev[EV_FF]) begin
          timer_load = 1'b1;
          state_d    = ST_ARMED;
        end
        if (ev[EV_OTHER]) err_inc = 1'b1;
      end
      ST_ARMED: begin
        if (ev == EV_KICK) begin
          timer_load = 1'b1;
        end else if (ev == EV_DIS) begin
          state_d = ST_DISABLED;
        end else if (multi_ev) begin
          err_inc = 1'b1;
        end else if (ev[EV_55]) begin
          state_d = ST_UNLOCK;
          win_d   = WIN_LOAD;
        end else if (ev[EV_OTHER]) begin
          err_inc = 1'b1;
        end
      end
      ST_UNLOCK: begin
        if (ev == EV_AAONLY) begin
          timer_load = 1'b1;
          state_d    = ST_ARMED;
        end else if (ev == EV_29ONLY) begin
          state_d = ST_DISABLED;
        end else if (ev != '0 || win_q <= WIN_W'(1)) begin
          err_inc = 1'b1;
          state_d = ST_ARMED;
        end else begin
          win_d = win_q - 1'b1;
        end
      end
      default: state_d = ST_DISABLED;
    endcase
    // A kick (timer reload) or disable in the terminal-count cycle wins.
    if (tc && !timer_load && state_d != ST_DISABLED) state_d = ST_EXPIRED;
  end

  always_ff @(posedge CLK32768) begin
    prev_q <= bus.bCPUWrWdtRegSig;
    if (MainReset) begin
      state_q   <= bus.WdtDefaultEn ? ST_ARMED : ST_DISABLED;
      active_q  <= bus.WdtDefaultEn;
      timeout_q <= 1'b0;
      exp_cnt_q <= '0;
      err_cnt_q <= '0;
      win_q     <= '0;
    end else begin
      state_q   <= state_d;
      active_q  <= (state_d == ST_ARMED) || (state_d == ST_UNLOCK);
      timeout_q <= (state_d == ST_EXPIRED);
      win_q     <= win_d;
      if (state_d == ST_EXPIRED) exp_cnt_q <= sat_inc(exp_cnt_q);
      if (err_inc) err_cnt_q <= sat_inc(err_cnt_q);
    end
  end

`ifdef BIOS_WDT_FAILOVER_EN
  logic sel_q;
  // Flip the flash select on each expiry so the next boot uses the other image.
  always_ff @(posedge CLK32768) begin
    if (MainReset) begin
      sel_q <= 1'b0;
    end else if (state_d == ST_EXPIRED) begin
      sel_q <= ~sel_q;
    end
  end
  assign bus.BiosSelect = sel_q;
`else
  assign bus.BiosSelect = 1'b0;
`endif

  assign bus.BiosWdtActive  = active_q;
  assign bus.BiosWdtTimeout = timeout_q;
  assign bus.BiosWdtExpCnt  = exp_cnt_q;
  assign bus.BiosWdtErrCnt  = err_cnt_q;
  assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_bios_wdt_ctrl.sv
// Directed bench for bios_wdt_ctrl with TIMEOUT_SEC=1 so two full expiries
// fit in the run; expected latencies are queued and popped per pulse.
module tb_bios_wdt_ctrl;
  import bios_wdt_pkg::*;

  localparam int unsigned T_SEC = 1;
  localparam int unsigned WIN   = 64;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [31:0] exp_q[$];
  logic exp_sel1, exp_sel2;

  bios_wdt_if bus();

  bios_wdt_ctrl #(.TIMEOUT_SEC(T_SEC), .UNLOCK_WIN(WIN)) dut (
    .CLK32768  (clk),
    .MainReset (rst),
    .bus       (bus)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Drivers
  task automatic toggle(input logic [EV_W-1:0] mask);
    bus.bCPUWrWdtRegSig = bus.bCPUWrWdtRegSig ^ mask;
  endtask

  task automatic wait_pulse(input string tag, input int limit);
    int n;
    logic [31:0] want;
    n = 0;
    while (bus.BiosWdtTimeout !== 1'b1 && n < limit) begin
      step(1);
      n++;
    end
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    check(tag, 32'(n), want);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
`ifdef BIOS_WDT_FAILOVER_EN
    exp_sel1 = 1'b1;
    exp_sel2 = 1'b0;
`else
    exp_sel1 = 1'b0;
    exp_sel2 = 1'b0;
`endif
    bus.bCPUWrWdtRegSig = '0;
    bus.WdtDefaultEn    = 1'b1;
    rst = 1'b1;
    step(3);
    check("rst_state", 32'(bus.dbg_state), 32'(ST_ARMED));
    check("rst_active", 32'(bus.BiosWdtActive), 32'd1);
    check("rst_timeout", 32'(bus.BiosWdtTimeout), 32'd0);
    check("rst_expcnt", 32'(bus.BiosWdtExpCnt), 32'd0);
    check("rst_errcnt", 32'(bus.BiosWdtErrCnt), 32'd0);
    check("rst_sel", 32'(bus.BiosSelect), 32'd0);
    rst = 1'b0;

    // Strap-armed expiry: load at the last reset edge.
    exp_q.push_back(32'(T_SEC * CLK_HZ));
    wait_pulse("post_lat", 40000);
    check("post_expcnt", 32'(bus.BiosWdtExpCnt), 32'd1);
    check("post_active", 32'(bus.BiosWdtActive), 32'd0);
    check("post_sel", 32'(bus.BiosSelect), 32'(exp_sel1));
    step(1);
    check("post_disabled", 32'(bus.dbg_state), 32'(ST_DISABLED));
    check("post_pulse_len", 32'(bus.BiosWdtTimeout), 32'd0);

    // Arm, unlock, kick: reload happens on the edge after the 0xAA toggle.
    step(2);
    toggle(5'b00100);
    step(1);
    check("arm_state", 32'(bus.dbg_state), 32'(ST_ARMED));
    check("arm_active", 32'(bus.BiosWdtActive), 32'd1);
    step(10);
    toggle(5'b00001);
    step(1);
    check("unlock_state", 32'(bus.dbg_state), 32'(ST_UNLOCK));
    check("unlock_active", 32'(bus.BiosWdtActive), 32'd1);
    step(4);
    toggle(5'b01000);
    exp_q.push_back(32'(T_SEC * CLK_HZ + 1));
    wait_pulse("kick_lat", 40000);
    check("kick_expcnt", 32'(bus.BiosWdtExpCnt), 32'd2);
    check("kick_sel", 32'(bus.BiosSelect), 32'(exp_sel2));
    check("kick_errcnt", 32'(bus.BiosWdtErrCnt), 32'd0);
    step(1);

    // Unlock then 0x29: disable, no error.
    toggle(5'b00100);
    step(3);
    toggle(5'b00001);
    step(3);
    toggle(5'b00010);
    step(1);
    check("dis_state", 32'(bus.dbg_state), 32'(ST_DISABLED));
    check("dis_active", 32'(bus.BiosWdtActive), 32'd0);
    check("dis_errcnt", 32'(bus.BiosWdtErrCnt), 32'd0);
    step(50);
    check("dis_hold", 32'(bus.dbg_state), 32'(ST_DISABLED));
    check("dis_no_pulse", 32'(bus.BiosWdtTimeout), 32'd0);

    // Same-cycle pairs from ARMED.
    toggle(5'b00100);
    step(3);
    toggle(5'b00101);
    step(1);
    check("pair_0_2_err", 32'(bus.BiosWdtErrCnt), 32'd1);
    check("pair_0_2_state", 32'(bus.dbg_state), 32'(ST_ARMED));
    step(2);
    toggle(5'b01001);
    step(1);
    check("pair_kick_state", 32'(bus.dbg_state), 32'(ST_ARMED));
    check("pair_kick_err", 32'(bus.BiosWdtErrCnt), 32'd1);
    step(2);
    toggle(5'b10000);
    step(1);
    check("other_err", 32'(bus.BiosWdtErrCnt), 32'd2);
    step(2);

    // Unlock window expiry: still UNLOCK after WIN steps, ARMED one later.
    toggle(5'b00001);
    step(WIN);
    check("win_edge_unlock", 32'(bus.dbg_state), 32'(ST_UNLOCK));
    step(1);
    check("win_expired_state", 32'(bus.dbg_state), 32'(ST_ARMED));
    check("win_expired_err", 32'(bus.BiosWdtErrCnt), 32'd3);
    for (int i = 0; i < 20; i++) begin
      step(2);
      toggle(5'b00001);
      step(WIN + 5);
    end
    check("err_saturate", 32'(bus.BiosWdtErrCnt), 32'd15);
    check("err_sat_state", 32'(bus.dbg_state), 32'(ST_ARMED));

    // Mid-count reset with strap low and an input toggle during reset.
    step(100);
    rst = 1'b1;
    bus.WdtDefaultEn = 1'b0;
    step(1);
    toggle(5'b10000);
    step(2);
    check("mid_rst_timeout", 32'(bus.BiosWdtTimeout), 32'd0);
    check("mid_rst_expcnt", 32'(bus.BiosWdtExpCnt), 32'd0);
    check("mid_rst_errcnt", 32'(bus.BiosWdtErrCnt), 32'd0);
    check("mid_rst_state", 32'(bus.dbg_state), 32'(ST_DISABLED));
    check("mid_rst_active", 32'(bus.BiosWdtActive), 32'd0);
    check("mid_rst_sel", 32'(bus.BiosSelect), 32'd0);
    rst = 1'b0;
    step(10);
    check("rel_no_event", 32'(bus.BiosWdtErrCnt), 32'd0);
    check("rel_state", 32'(bus.dbg_state), 32'(ST_DISABLED));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
